// File: rtl/life_pkg.sv
// life_pkg: shared types and rule constants for the Game-of-Life neighbour stage.
// The optional macro LIFE_HIGHLIFE_EN is used by life_rule. It is not used here.
package life_pkg;

   // A total neighbour count can be 0..8 after combining two partial sums.
   typedef logic [3:0] count_t;

   // Each partial sum comes from an upstream 2-bit-to-3-bit adder.
   typedef logic [2:0] partial_t;

   localparam count_t   BIRTH_CNT     = 4'd3;
   localparam count_t   BIRTH_ALT_CNT = 4'd6;
   localparam count_t   SURVIVE_LO    = 4'd2;
   localparam count_t   SURVIVE_HI    = 4'd3;
   localparam partial_t PARTIAL_MAX   = 3'd4;

   // Widen both partials before adding them, so the carry is kept (no truncation).
   function automatic count_t add_partials(input partial_t a, input partial_t b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/life_rule.sv
// life_rule: combinational next-state rule for one cell.
// Default rule: B3/S23.
// Defining LIFE_HIGHLIFE_EN selects B36/S23, which adds birth on 6 neighbours.
module life_rule
   import life_pkg::*;
(
   input  logic   alive,
   input  count_t count,
   output logic   next_alive,
   output logic   born,
   output logic   died
);

   logic birth;
   logic survive;

`ifdef LIFE_HIGHLIFE_EN
   assign birth = (count == BIRTH_CNT) || (count == BIRTH_ALT_CNT);
`else
   assign birth = (count == BIRTH_CNT);
`endif

   assign survive = (count >= SURVIVE_LO) && (count <= SURVIVE_HI);

   // A dead cell can only be born and a live cell can only survive.
   // Because of this, the birth counts never keep a live cell alive.
   always_comb begin
      next_alive = alive ? survive : birth;
      born       = !alive && next_alive;
      died       = alive && !next_alive;
   end

endmodule

// File: rtl/neighbor_rule_stage.sv
// neighbor_rule_stage: two-stage valid/ready pipeline.
//   Stage S1 adds the two partial neighbour counts.
//   Stage S2 applies the life rule.
// Per-generation statistics are kept at the output handshake.
// The rule variant is chosen by the LIFE_HIGHLIFE_EN macro inside life_rule.
module neighbor_rule_stage
   import life_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_sum_lo,
   input  logic [2:0]       in_sum_hi,
   input  logic             in_alive,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_alive,
   output logic [3:0]       out_count,
   output logic             out_born,
   output logic             out_died,
   output logic             out_last,
   output logic [CNT_W-1:0] gen_count,
   output logic [CNT_W-1:0] pop_final,
   output logic             extinct,
   output logic             count_err
);

   // run holds in_ready low during reset.
   // It rises on the first clock edge after reset is released.
   logic             run;
   logic             s1_valid;
   count_t           s1_count;
   logic             s1_alive;
   logic             s1_last;
   logic [CNT_W-1:0] pop_acc;

   logic             s2_ready;
   logic             s1_adv;
   logic             in_fire;
   logic             out_fire;
   logic             partial_err;
   logic             rule_alive;
   logic             rule_born;
   logic             rule_died;
   logic [CNT_W-1:0] pop_next;

   assign s2_ready    = !out_valid || out_ready;
   assign s1_adv      = s1_valid && s2_ready;
   assign in_ready    = run && (!s1_valid || s2_ready);
   assign in_fire     = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign partial_err = (in_sum_lo > PARTIAL_MAX) || (in_sum_hi > PARTIAL_MAX);

   // The population count saturates so that a very large generation pins at the maximum value.
   assign pop_next = (pop_acc == '1) ? pop_acc : pop_acc + CNT_W'(out_alive);

   life_rule u_rule (
      .alive      (s1_alive),
      .count      (s1_count),
      .next_alive (rule_alive),
      .born       (rule_born),
      .died       (rule_died)
   );

   // S1: capture the combined neighbour count and the cell flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         s1_valid <= 1'b0;
         s1_count <= '0;
         s1_alive <= 1'b0;
         s1_last  <= 1'b0;
      end else begin
         run <= 1'b1;
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_count <= add_partials(in_sum_lo, in_sum_hi);
            s1_alive <= in_alive;
            s1_last  <= in_last;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // S2: register the rule result.
   // The payload is held while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_alive <= 1'b0;
         out_count <= '0;
         out_born  <= 1'b0;
         out_died  <= 1'b0;
         out_last  <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         out_alive <= rule_alive;
         out_count <= s1_count;
         out_born  <= rule_born;
         out_died  <= rule_died;
         out_last  <= s1_last;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   // Generation statistics are updated on output handshakes.
   // The error flag is sticky and is set on bad partial sums at the input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_acc   <= '0;
         pop_final <= '0;
         gen_count <= '0;
         extinct   <= 1'b0;
         count_err <= 1'b0;
      end else begin
         if (in_fire && partial_err) begin
            count_err <= 1'b1;
         end
         if (out_fire) begin
            if (out_last) begin
               pop_final <= pop_next;
               pop_acc   <= '0;
               gen_count <= gen_count + CNT_W'(1);
               extinct   <= (pop_next == '0);
            end else begin
               pop_acc <= pop_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_neighbor_rule_stage.sv
// tb_neighbor_rule_stage: directed, self-checking bench for neighbor_rule_stage.
// The expected results follow the macro LIFE_HIGHLIFE_EN, so the bench matches either rule variant.
module tb_neighbor_rule_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_sum_lo = '0;
   logic [2:0]  in_sum_hi = '0;
   logic        in_alive = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_alive;
   logic [3:0]  out_count;
   logic        out_born;
   logic        out_died;
   logic        out_last;
   logic [15:0] gen_count;
   logic [15:0] pop_final;
   logic        extinct;
   logic        count_err;

   int compared = 0;
   int mismatched = 0;

`ifdef LIFE_HIGHLIFE_EN
   localparam bit HL = 1'b1;
`else
   localparam bit HL = 1'b0;
`endif

   neighbor_rule_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum_lo(in_sum_lo), .in_sum_hi(in_sum_hi),
      .in_alive(in_alive), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alive(out_alive), .out_count(out_count),
      .out_born(out_born), .out_died(out_died), .out_last(out_last),
      .gen_count(gen_count), .pop_final(pop_final),
      .extinct(extinct), .count_err(count_err)
   );

   always #5 clk = ~clk;

   // Packed output payload: {alive, count[3:0], born, died, last}
   function automatic logic [7:0] payload();
      return {out_alive, out_count, out_born, out_died, out_last};
   endfunction

   // Reference rule, written from the B3/S23 and B36/S23 definitions.
   function automatic logic [7:0] expect_cell(input logic alive, input int count, input logic last);
      logic nxt;
      if (alive) nxt = (count == 2) || (count == 3);
      else       nxt = (count == 3) || (HL && count == 6);
      return {nxt, 4'(count), !alive && nxt, alive && !nxt, last};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one cell and wait for its input handshake.
   // The task returns 1 time unit after the accepting edge.
   task automatic push(input logic alive, input logic [2:0] lo, input logic [2:0] hi,
                       input logic last, input bit hold);
      bit ok = 1'b0;
      in_valid = 1'b1; in_alive = alive; in_sum_lo = lo; in_sum_hi = hi; in_last = last;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
      $display("push alive=%0d lo=%0d hi=%0d last=%0d", alive, lo, hi, last);
   endtask

   // Wait for out_valid, then compare the payload with the expected value.
   // out_ready is assumed to be 1, so the handshake completes on the next edge.
   task automatic get_out(input string tag, input logic [7:0] exp);
      bit ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
      else     check(tag, payload(), exp);
      $display("out %s payload=%02h expected=%02h", tag, payload(), exp);
      @(posedge clk); #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   int         got = 0;
   bit         saw_full = 1'b0;
   logic [7:0] exp_q[$];
   logic       hold_prev = 1'b0;
   logic [7:0] prev_pl = '0;
   bit         ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      // ---- Reset state, checked while rst_n is low ----
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_payload", payload(), 0);
      check("rst_gen", gen_count, 0);
      check("rst_pop", pop_final, 0);
      check("rst_flags", {extinct, count_err}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rdy_before_edge", in_ready, 0);
      @(posedge clk); #1;
      check("rdy_after_edge", in_ready, 1);

      // ---- Two-cycle latency, then the basic rule cases ----
      push(1'b0, 3'd1, 3'd2, 1'b0, 1'b0);
      check("lat_1cyc", out_valid, 0);
      @(posedge clk); #1;
      check("lat_2cyc", out_valid, 1);
      check("birth3", payload(), {1'b1, 4'd3, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
      push(1'b1, 3'd4, 3'd0, 1'b0, 1'b0);
      get_out("overcrowd", {1'b0, 4'd4, 1'b0, 1'b1, 1'b0});
      push(1'b1, 3'd1, 3'd1, 1'b0, 1'b0);
      get_out("survive2", {1'b1, 4'd2, 1'b0, 1'b0, 1'b0});
      wait_cycles(2);
      check("nolast_gen", gen_count, 0);

      // ---- Generation statistics: alive pattern 1,0,1,1,0 ----
      pulse_reset();
      push(1'b0, 3'd2, 3'd1, 1'b0, 1'b0);
      push(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      push(1'b1, 3'd2, 3'd0, 1'b0, 1'b0);
      push(1'b1, 3'd3, 3'd0, 1'b0, 1'b0);
      wait_cycles(3);
      check("midgen_gen", gen_count, 0);
      check("midgen_pop", pop_final, 0);
      push(1'b1, 3'd4, 3'd0, 1'b1, 1'b0);
      wait_cycles(3);
      check("gen1_pop", pop_final, 3);
      check("gen1_count", gen_count, 1);
      check("gen1_extinct", extinct, 0);
      push(1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
      push(1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
      push(1'b0, 3'd4, 3'd4, 1'b1, 1'b0);
      wait_cycles(3);
      check("gen2_pop", pop_final, 0);
      check("gen2_count", gen_count, 2);
      check("gen2_extinct", extinct, 1);

      // ---- Stream 10 cells while out_ready follows 1,0,0,1 ----
      for (int i = 0; i < 10; i++)
         exp_q.push_back(expect_cell(1'(i % 2), (i % 5) + ((i * 2) % 5), i == 9));
      fork
         begin
            for (int i = 0; i < 10; i++)
               push(1'(i % 2), 3'(i % 5), 3'((i * 2) % 5), i == 9, 1'b1);
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 300 && got < 10; c++) begin
               @(posedge clk); #1 out_ready = ready_pat[c % 4];
            end
         end
         begin
            for (int c = 0; c < 300 && got < 10; c++) begin
               @(negedge clk);
               if (hold_prev) check("stall_stable", payload(), prev_pl);
               if (!in_ready) check("rdy_low_only_full", {out_valid, out_ready}, 2'b10);
               if (in_valid && !in_ready) saw_full = 1'b1;
               if (out_valid && out_ready) begin
                  check("stream_data", payload(), exp_q[got]);
                  $display("stream out %0d payload=%02h", got, payload());
                  got++;
               end
               hold_prev = out_valid && !out_ready;
               prev_pl   = payload();
            end
         end
      join
      out_ready = 1'b1;
      check("stream_count", got, 10);
      check("stream_backpressure", saw_full, 1);
      wait_cycles(3);
      check("stream_gen", gen_count, 3);

      // ---- Sticky count_err, then a reset in the middle of the stream ----
      push(1'b0, 3'd5, 3'd0, 1'b0, 1'b0);
      check("err_set", count_err, 1);
      get_out("err_rawsum", expect_cell(1'b0, 5, 1'b0));
      push(1'b0, 3'd1, 3'd1, 1'b0, 1'b0);
      get_out("legal_after_err", expect_cell(1'b0, 2, 1'b0));
      check("err_sticky", count_err, 1);
      push(1'b0, 3'd1, 3'd2, 1'b1, 1'b1);
      rst_n = 1'b0; in_valid = 1'b0;
      #2;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 0);
      check("midrst_payload", payload(), 0);
      check("midrst_stats", {gen_count, pop_final}, 0);
      check("midrst_flags", {extinct, count_err}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_rdy_pre", in_ready, 0);
      @(posedge clk); #1;
      check("midrst_rdy_post", in_ready, 1);
      wait_cycles(2);
      check("midrst_discard", out_valid, 0);

      // ---- Dead cell with 6 neighbours; this cell is the only cell of generation 0 ----
      push(1'b0, 3'd3, 3'd3, 1'b1, 1'b0);
      get_out("six_nbrs", {HL, 4'd6, HL, 1'b0, 1'b1});
      check("hl_gen", gen_count, 1);
      check("hl_pop", pop_final, 32'(HL));
      check("hl_extinct", extinct, !HL);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Overall time limit: the run always ends, even if the design hangs.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
